// File: rtl/mem_pkg.sv
// Shared types and default widths for the backing-memory controller and its
// write-back buffer.
package mem_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_mem_ctrl_if.sv
// Cache-to-backing-memory bus: victim write-backs plus line-fill reads.
// The cache drives the master side and the controller is the slave.
interface wb_mem_ctrl_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_adr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output wr_req, wr_adr, wr_data, rd_req, rd_adr,
    input  wr_ready, rd_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  wr_req, wr_adr, wr_data, rd_req, rd_adr,
    output wr_ready, rd_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Write-back buffer: FIFO of {adr,data} entries.
// A combinational lookup returns the youngest live entry matching an address.
module wb_fifo
  import mem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  wb_entry_t                 i_push_entry,
  input  logic                      i_pop,
  output wb_entry_t                 o_head,
  output logic [$clog2(WB_DEPTH):0] o_count,
  output logic                      o_full,
  output logic                      o_empty,
  input  logic [ADDR_W-1:0]         i_lookup_adr,
  output logic                      o_hit,
  output logic [DATA_W-1:0]         o_hit_data
);

  localparam int PTR_W = $clog2(WB_DEPTH);

  wb_entry_t        r_mem [WB_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!i_push && i_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == (PTR_W+1)'(WB_DEPTH));
  assign o_empty = (r_count == '0);

  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    // Walk oldest to youngest; a later match overrides an earlier one.
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((PTR_W+1)'(i) < r_count) && (r_mem[r_head + PTR_W'(i)].adr == i_lookup_adr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[r_head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/wb_mem_ctrl.sv
// Backing-memory controller: 2**ADDR_W x DATA_W array, background-drained
// write-back buffer, and line-fill reads with buffer forwarding.
module wb_mem_ctrl #(
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int WB_DEPTH = 4,
  parameter int READ_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  wb_mem_ctrl_if.slave  bus
);

  import mem_pkg::*;

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_lat;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  wb_entry_t         w_push_entry;
  wb_entry_t         w_head;
  logic [PTR_W:0]    w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_wr_acc;
  logic              w_pop;
  logic              w_same;
  logic              w_fwd;
  logic              w_lat0;
  logic [DATA_W-1:0] w_arr_data;
  logic [DATA_W-1:0] w_rd_sel;

  assign w_wr_acc     = bus.wr_req && !w_full;
  assign w_pop        = !w_empty;
  assign w_push_entry = '{adr: bus.wr_adr, data: bus.wr_data};

  wb_fifo #(.WB_DEPTH(WB_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_wr_acc),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .i_lookup_adr (bus.rd_adr),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  // The incoming write is younger than anything already buffered.
  assign w_same     = w_wr_acc && (bus.wr_adr == bus.rd_adr);
  assign w_fwd      = w_same || w_hit;
  assign w_lat0     = w_fwd || (READ_LAT == 1);
  assign w_arr_data = (w_pop && (w_head.adr == bus.rd_adr)) ? w_head.data : r_mem[bus.rd_adr];
  assign w_rd_sel   = w_same ? bus.wr_data : (w_hit ? w_hit_data : w_arr_data);

  // Array is cleared on reset so post-reset reads return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (w_pop) begin
      r_mem[w_head.adr] <= w_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lat      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rd_req) begin
            r_state <= WAIT;
            if (w_lat0) begin
              r_cnt      <= '0;
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_rd_sel;
            end else begin
              r_cnt <= CNT_W'(READ_LAT - 1);
              r_lat <= w_rd_sel;
            end
          end
        end
        WAIT: begin
          // rd_valid is registered, so it is raised on the edge into cnt==0.
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= r_lat;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready = !w_full;
  assign bus.rd_ready = (r_state == IDLE);
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.busy     = (r_state == WAIT) || (w_count != '0);

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Self-checking bench for wb_mem_ctrl: directed vector table plus randomized
// traffic compared against a queue-and-array reference model.
module tb_wb_mem_ctrl;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int WB_DEPTH = 4;
  localparam int READ_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_mem_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WB_DEPTH (WB_DEPTH),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, m_edge, act, exp);
    end
  endtask

  // Reference model: memory array, FIFO queue, and absolute response times.
  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } went_t;

  logic [DATA_W-1:0] m_mem [2**ADDR_W];
  went_t             m_buf [$];
  int                m_edge    = 0;
  int                m_done    = -1;
  logic [DATA_W-1:0] m_pend    = '0;
  logic [DATA_W-1:0] m_rd_data = '0;
  logic              m_valid   = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 2**ADDR_W; i++) m_mem[i] = '0;
    m_buf.delete();
    m_done    = -1;
    m_rd_data = '0;
    m_valid   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check ready/busy, clock, check the response.
  task automatic step(input bit rst, input bit wr, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input bit rd, input logic [ADDR_W-1:0] ra);
    bit                rdy_w, rdy_r, acc_w, acc_r, fwd;
    logic [DATA_W-1:0] val;
    reset       = rst;
    bus.wr_req  = wr;
    bus.wr_adr  = wa;
    bus.wr_data = wd;
    bus.rd_req  = rd;
    bus.rd_adr  = ra;
    rdy_w = (m_buf.size() != WB_DEPTH);
    rdy_r = (m_edge > m_done);
    check("wr_ready", 32'(bus.wr_ready), 32'(rdy_w));
    check("rd_ready", 32'(bus.rd_ready), 32'(rdy_r));
    check("busy", 32'(bus.busy), 32'(!rdy_r || (m_buf.size() != 0)));
    @(posedge clk);
    if (rst) begin
      model_reset();
      m_edge++;
    end else begin
      acc_w = wr && rdy_w;
      acc_r = rd && rdy_r;
      if (acc_r) begin
        fwd = 1'b0;
        val = '0;
        if (acc_w && (wa == ra)) begin
          fwd = 1'b1;
          val = wd;
        end else begin
          for (int i = m_buf.size() - 1; i >= 0; i--) begin
            if (m_buf[i].adr == ra) begin
              fwd = 1'b1;
              val = m_buf[i].data;
              break;
            end
          end
        end
        if (!fwd) val = m_mem[ra];
        m_pend = val;
        m_done = m_edge + 1 + (fwd ? 0 : READ_LAT - 1);
      end
      if (m_buf.size() != 0) begin
        m_mem[m_buf[0].adr] = m_buf[0].data;
        void'(m_buf.pop_front());
      end
      if (acc_w) m_buf.push_back('{adr: wa, data: wd});
      m_edge++;
      m_valid = (m_edge == m_done);
      if (m_valid) m_rd_data = m_pend;
    end
    #1;
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    check("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
  endtask

  // Directed vectors: inputs for one cycle and hand-derived outputs after its edge.
  typedef struct {
    bit                rst;
    bit                wr;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    bit                rd;
    logic [ADDR_W-1:0] ra;
    bit                ev;
    logic [DATA_W-1:0] ed;
    bit                erdy;
    bit                ebusy;
  } vec_t;

  vec_t vecs [$];

  task automatic v(input bit rst, input bit wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                   input bit rd, input logic [ADDR_W-1:0] ra,
                   input bit ev, input logic [DATA_W-1:0] ed, input bit erdy, input bit ebusy);
    vec_t t;
    t.rst = rst; t.wr = wr; t.wa = wa; t.wd = wd; t.rd = rd; t.ra = ra;
    t.ev = ev; t.ed = ed; t.erdy = erdy; t.ebusy = ebusy;
    vecs.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then read 0x2A on the array path: three cycles not ready, data 0.
    v(1, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h2A,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);
    // Same-cycle write and read of 0x15 forwards; later array read returns it.
    v(0, 1, 6'h15, 8'hA5, 1, 6'h15,  1, 8'hA5, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'hA5, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h15,  0, 8'hA5, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'hA5, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'hA5, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'hA5, 1, 0);
    // Back-to-back writes to 0x07; the incoming write is the youngest match.
    v(0, 1, 6'h07, 8'h11, 0, 6'h00,  0, 8'hA5, 1, 1);
    v(0, 1, 6'h07, 8'h22, 1, 6'h07,  1, 8'h22, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h22, 1, 0);
    // Forward from a buffered (still draining) entry.
    v(0, 1, 6'h07, 8'h33, 0, 6'h00,  0, 8'h22, 1, 1);
    v(0, 0, 6'h00, 8'h00, 1, 6'h07,  1, 8'h33, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h33, 1, 0);
    // Read 0x30 in WAIT while six writes stream in; later write must not leak.
    v(0, 0, 6'h00, 8'h00, 1, 6'h30,  0, 8'h33, 0, 1);
    v(0, 1, 6'h30, 8'h60, 0, 6'h00,  0, 8'h33, 0, 1);
    v(0, 1, 6'h31, 8'h61, 0, 6'h00,  1, 8'h00, 0, 1);
    v(0, 1, 6'h32, 8'h62, 0, 6'h00,  0, 8'h00, 1, 1);
    v(0, 1, 6'h33, 8'h63, 0, 6'h00,  0, 8'h00, 1, 1);
    v(0, 1, 6'h34, 8'h64, 0, 6'h00,  0, 8'h00, 1, 1);
    v(0, 1, 6'h35, 8'h65, 0, 6'h00,  0, 8'h00, 1, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h30,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'h60, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h60, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h35,  0, 8'h60, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h60, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'h65, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h65, 1, 0);
    // Five consecutive writes to one address: none lost, last one wins.
    v(0, 1, 6'h3F, 8'h41, 0, 6'h00,  0, 8'h65, 1, 1);
    v(0, 1, 6'h3F, 8'h42, 0, 6'h00,  0, 8'h65, 1, 1);
    v(0, 1, 6'h3F, 8'h43, 0, 6'h00,  0, 8'h65, 1, 1);
    v(0, 1, 6'h3F, 8'h44, 0, 6'h00,  0, 8'h65, 1, 1);
    v(0, 1, 6'h3F, 8'h45, 1, 6'h3F,  1, 8'h45, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h45, 1, 0);
    // Reset during WAIT with writes in flight: no response, everything cleared.
    v(0, 1, 6'h01, 8'hAA, 1, 6'h02,  0, 8'h45, 0, 1);
    v(0, 1, 6'h02, 8'hBB, 0, 6'h00,  0, 8'h45, 0, 1);
    v(1, 1, 6'h03, 8'hCC, 0, 6'h00,  0, 8'h00, 1, 0);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h02,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);
    v(0, 0, 6'h00, 8'h00, 1, 6'h01,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  1, 8'h00, 0, 1);
    v(0, 0, 6'h00, 8'h00, 0, 6'h00,  0, 8'h00, 1, 0);

    // Bring the DUT out of its unknown power-up state before any checks.
    model_reset();
    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.wr_adr  = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_adr  = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
      check($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d_rd_ready", i), 32'(bus.rd_ready), 32'(vecs[i].erdy));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].ebusy));
    end

    // Random traffic on a narrow address window so forwarding hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      bit                rst, wr, rd;
      logic [ADDR_W-1:0] wa, ra;
      logic [DATA_W-1:0] wd;
      rst = ($urandom_range(399) == 0);
      wr  = ($urandom_range(99) < 55);
      rd  = ($urandom_range(99) < 40);
      wa  = ($urandom_range(3) == 0) ? ADDR_W'($urandom_range(63)) : ADDR_W'($urandom_range(7));
      ra  = ($urandom_range(3) == 0) ? ADDR_W'($urandom_range(63)) : ADDR_W'($urandom_range(7));
      wd  = DATA_W'($urandom);
      step(rst, wr, wa, wd, rd, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
